// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings and default latencies for the multiply/divide sequencer.
// MADD/MADDU/MSUB are recognised as multiply-class ops only when MDU_MADD_EN is defined.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_DIV_RUN = 2'd2
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op == MD_MULT || op == MD_MULTU || op == MD_MADD || op == MD_MADDU || op == MD_MSUB;
`else
        return op == MD_MULT || op == MD_MULTU;
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {HI,LO} result for a multiply/divide op.
// Divide by zero returns the current {HI,LO}; MADD family only with MDU_MADD_EN.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [63:0] sdiv;
    logic [63:0] udiv;
    logic [63:0] base;
    logic        dz;
    logic        ovf;

    assign dz    = rt_val == 32'd0;
    assign ovf   = rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF;
    assign sprod = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign uprod = {32'd0, rs_val} * {32'd0, rt_val};
    // The most-negative / -1 quotient overflows 32 bits; pin it to the wrapped value.
    assign sdiv  = ovf ? {32'd0, 32'h8000_0000}
                       : {$signed(rs_val) % $signed(rt_val), $signed(rs_val) / $signed(rt_val)};
    assign udiv  = {rs_val % rt_val, rs_val / rt_val};

    assign base = op == MD_MULT            ? sprod :
                  op == MD_MULTU           ? uprod :
                  (op == MD_DIV  && !dz)   ? sdiv  :
                  (op == MD_DIVU && !dz)   ? udiv  :
                  {hi, lo};

`ifdef MDU_MADD_EN
    assign result = op == MD_MADD  ? {hi, lo} + sprod :
                    op == MD_MADDU ? {hi, lo} + uprod :
                    op == MD_MSUB  ? {hi, lo} - sprod :
                    base;
`else
    assign result = base;
`endif

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: E-stage multiply/divide controller owning HI/LO with multi-cycle busy sequencing.
// Optional MADD/MADDU/MSUB support is enabled by defining MDU_MADD_EN.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state;
    logic [CW-1:0] counter;
    logic [63:0] pending;
    logic [63:0] res;
    logic        accept;
    logic        go_mul;
    logic        go_div;

    assign accept  = start & ~req & (state == S_IDLE);
    assign go_mul  = accept & is_mul(op);
    assign go_div  = accept & is_div(op);
    assign busy    = go_mul | go_div | (state != S_IDLE);
    assign rd_data = op == MD_MFHI ? hi : op == MD_MFLO ? lo : 32'd0;

    md_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi     (hi),
        .lo     (lo),
        .result (res)
    );

    // The result is captured at accept so operands may change while running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            counter <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_mul || go_div) begin
                        pending <= res;
                        counter <= go_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                        state   <= go_mul ? S_MUL_RUN : S_DIV_RUN;
                    end
                    if (accept && op == MD_MTHI) hi <= rs_val;
                    if (accept && op == MD_MTLO) lo <= rs_val;
                end
                default: begin
                    if (counter == '0) begin
                        hi    <= pending[63:32];
                        lo    <= pending[31:0];
                        state <= S_IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized self-checking bench for md_sequencer against a plain-arithmetic HI/LO model.
// Build with MDU_MADD_EN defined to exercise MADD/MADDU/MSUB instead of their ignored behaviour.
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .req     (req),
        .busy    (busy),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Reference: new {HI,LO} and total busy cycles for one accepted op.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [63:0] res, output int bl);
        longint sa;
        longint sb;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {h, l};
        res = acc;
        bl  = 0;
        case (o)
            4'd1: begin res = sa * sb; bl = MC + 1; end
            4'd2: begin res = {32'd0, a} * {32'd0, b}; bl = MC + 1; end
            4'd3: begin bl = DC + 1; if (b != 0) res = {32'(sa % sb), 32'(sa / sb)}; end
            4'd4: begin bl = DC + 1; if (b != 0) res = {a % b, a / b}; end
            4'd5: res = {a, l};
            4'd6: res = {h, a};
`ifdef MDU_MADD_EN
            4'd9:  begin res = acc + 64'(sa * sb); bl = MC + 1; end
            4'd10: begin res = acc + {32'd0, a} * {32'd0, b}; bl = MC + 1; end
            4'd11: begin res = acc - 64'(sa * sb); bl = MC + 1; end
`endif
            default: ;
        endcase
    endfunction

    task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input logic req_run);
        logic [63:0] exp;
        int bl;
        int n;
        model(o, a, b, mhi, mlo, exp, bl);
        if (r) begin
            exp = {mhi, mlo};
            bl  = 0;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_before_start: busy=%b required 0", name, busy);
        end
        start = 1'b1; op = o; rs_val = a; rt_val = b; req = r;
        #1;
        checks++;
        if (busy !== (bl > 0)) begin
            errors++;
            $display("FAIL %s busy_at_issue: busy=%b required %b", name, busy, bl > 0);
        end
        if (o == 4'd7 || o == 4'd8) begin
            checks++;
            if (rd_data !== (o == 4'd7 ? mhi : mlo)) begin
                errors++;
                $display("FAIL %s rd_data: got %h required %h", name, rd_data, o == 4'd7 ? mhi : mlo);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; req = req_run;
        n = (bl > 0) ? 1 : 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        checks++;
        if (n !== bl) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, n, bl);
        end
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h required %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
        mhi = exp[63:32];
        mlo = exp[31:0];
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || rd_data !== 32'd0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd=%h hi=%h lo=%h required 0/0/0/0", busy, rd_data, hi, lo);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        do_op("mult_neg2x3", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const: got %h_%h required ffffffff_fffffffa", hi, lo);
        end
        do_op("mfhi_after_mult", 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op("mflo_after_mult", 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_div();
        do_op("div_neg7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const: got %h_%h required ffffffff_fffffffd", hi, lo);
        end
        do_op("divu_by_zero", 4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        do_op("div_by_zero", 4'd3, 32'd9, 32'd0, 1'b0, 1'b0);
        do_op("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow_const: got %h_%h required 00000000_80000000", hi, lo);
        end
        do_op("divu_big", 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    endtask

    task automatic test_move();
        do_op("mtlo", 4'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_op("mtlo_req", 4'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        do_op("mthi", 4'd5, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        do_op("mfhi", 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_req();
        do_op("multu_req", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("div_req_in_run", 4'd3, 32'd100, 32'hFFFF_FFFD, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 4'd3; rs_val = 32'd1000; rt_val = 32'd7; req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        mhi = 32'd0;
        mlo = 32'd0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        do_op("after_reset_mult", 4'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    endtask

    task automatic test_madd();
        do_op("madd_mthi", 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op("madd_mtlo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        do_op("maddu_1x1", 4'd10, 32'd1, 32'd1, 1'b0, 1'b0);
        do_op("madd_neg", 4'd9, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        do_op("msub", 4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            logic [31:0] a;
            logic [31:0] b;
            o = 4'($urandom_range(0, 11));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
            do_op("random", o, a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_req();
        test_reset_mid();
        test_madd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
